// File: rtl/enable_receiver.sv
// Consumer of the staggered ena_1/ena_2/ena_3 sequence in the clkB domain: checks legality,
// captures one sample per stage and returns a result word plus a toggle ack. Optional VOTE_EN.
module enable_receiver #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clkB,
  input  logic          rst_n,
  input  logic          ena_1,
  input  logic          ena_2,
  input  logic          ena_3,
  input  logic          done,
  input  logic [W-1:0]  data_in,
  input  logic          err_clr,
  output logic [W-1:0]  data_out,
  output logic          valid,
  output logic          ack_tgl,
  output logic          err,
  output logic          mismatch,
  output logic [CW-1:0] seq_cnt,
  output logic          busy
);

  typedef enum logic [2:0] {IDLE, S1, S2, S3, DONE, ERR} state_t;

  state_t        state_q, state_d;
  logic [2:0]    pat;
  logic          finish;
  logic [W-1:0]  s3_q;
  logic [W-1:0]  result;
  logic [W-1:0]  data_out_q;
  logic          valid_q, ack_q, err_q, busy_q;
  logic [CW-1:0] cnt_q;

  assign pat    = {ena_1, ena_2, ena_3};
  assign finish = (state_q == S3) && (pat == 3'b000) && done;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pat == 3'b000 && !done)      state_d = IDLE;
        else if (pat == 3'b111 && !done) state_d = S1;
        else                             state_d = ERR;
      end
      S1:   state_d = (pat == 3'b011 && !done) ? S2 : ERR;
      S2:   state_d = (pat == 3'b001 && !done) ? S3 : ERR;
      S3:   state_d = finish ? DONE : ERR;
      DONE: begin
        if (pat == 3'b000 && done)       state_d = DONE;
        else if (pat == 3'b000 && !done) state_d = IDLE;
        else if (pat == 3'b111 && !done) state_d = S1;
        else                             state_d = ERR;
      end
      ERR:  state_d = (pat == 3'b000 && !done) ? IDLE : ERR;
      default: state_d = ERR;
    endcase
  end

`ifdef VOTE_EN
  logic [W-1:0] s1_q, s2_q;
  logic         mismatch_q;

  assign result   = (s1_q & s2_q) | (s2_q & s3_q) | (s1_q & s3_q);
  assign mismatch = mismatch_q;

  always_ff @(posedge clkB or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (state_d == S1) s1_q <= data_in;
      if (state_d == S2) s2_q <= data_in;
      if (finish)        mismatch_q <= (s1_q != s2_q) | (s2_q != s3_q);
    end
  end
`else
  assign result   = s3_q;
  assign mismatch = 1'b0;
`endif

  // Stage states are never re-entered from themselves, so state_d alone marks a capture edge.
  always_ff @(posedge clkB or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s3_q       <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= finish;
      busy_q  <= (state_d == S1) || (state_d == S2) || (state_d == S3);
      if (state_d == S3) s3_q <= data_in;
      if (finish) begin
        data_out_q <= result;
        ack_q      <= ~ack_q;
        cnt_q      <= cnt_q + CW'(1);
      end
      if (state_d == ERR && state_q != ERR) err_q <= 1'b1;
      else if (err_clr)                     err_q <= 1'b0;
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;
  assign ack_tgl  = ack_q;
  assign err      = err_q;
  assign seq_cnt  = cnt_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_enable_receiver.sv
// Directed, table-driven bench for enable_receiver; expectations follow VOTE_EN when defined.
module tb_enable_receiver;

  localparam int W  = 8;
  localparam int CW = 4;
`ifdef VOTE_EN
  localparam logic MM2 = 1'b1;
`else
  localparam logic MM2 = 1'b0;
`endif

  logic          clkB = 1'b0;
  logic          rst_n, ena_1, ena_2, ena_3, done, err_clr;
  logic [W-1:0]  data_in, data_out;
  logic          valid, ack_tgl, err, mismatch, busy;
  logic [CW-1:0] seq_cnt;

  int checks = 0;
  int passed = 0;
  int validSeen;

  typedef struct {
    logic [2:0] p;
    logic       dn;
    logic [7:0] d;
    logic       clr;
    logic       eValid;
    logic [7:0] eDout;
    logic       eAck;
    logic       eErr;
    logic [3:0] eCnt;
    logic       eBusy;
    logic       eMm;
  } vec_t;

  vec_t vecs[$];

  enable_receiver #(.W(W), .CW(CW)) dut (
    .clkB(clkB), .rst_n(rst_n), .ena_1(ena_1), .ena_2(ena_2), .ena_3(ena_3),
    .done(done), .data_in(data_in), .err_clr(err_clr), .data_out(data_out),
    .valid(valid), .ack_tgl(ack_tgl), .err(err), .mismatch(mismatch),
    .seq_cnt(seq_cnt), .busy(busy)
  );

  always #5 clkB = ~clkB;

  function automatic vec_t mk(logic [2:0] p, logic dn, logic [7:0] d, logic clr,
                              logic v, logic [7:0] o, logic a, logic e,
                              logic [3:0] c, logic b, logic m);
    vec_t t;
    t.p = p; t.dn = dn; t.d = d; t.clr = clr;
    t.eValid = v; t.eDout = o; t.eAck = a; t.eErr = e;
    t.eCnt = c; t.eBusy = b; t.eMm = m;
    return t;
  endfunction

  task automatic checkOutput(input string nm, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
  endtask

  // Drive one cycle of inputs on the falling edge, then settle just after the rising edge.
  task automatic applyStimulus(input logic [2:0] p, input logic dn,
                               input logic [7:0] d, input logic clr);
    @(negedge clkB);
    {ena_1, ena_2, ena_3} = p;
    done    = dn;
    data_in = d;
    err_clr = clr;
    @(posedge clkB);
    #1;
    if (valid === 1'b1) validSeen++;
  endtask

  task automatic checkAll(input int idx, input vec_t t);
    checkOutput("valid",    idx, 32'(valid),    32'(t.eValid));
    checkOutput("data_out", idx, 32'(data_out), 32'(t.eDout));
    checkOutput("ack_tgl",  idx, 32'(ack_tgl),  32'(t.eAck));
    checkOutput("err",      idx, 32'(err),      32'(t.eErr));
    checkOutput("seq_cnt",  idx, 32'(seq_cnt),  32'(t.eCnt));
    checkOutput("busy",     idx, 32'(busy),     32'(t.eBusy));
    checkOutput("mismatch", idx, 32'(mismatch), 32'(t.eMm));
  endtask

  initial begin
    vec_t zero;
    logic [7:0] dk;

    // Legal sequence at 0xA5, DONE held, then back to IDLE.
    vecs.push_back(mk(3'b111, 0, 8'hA5, 0, 0, 8'h00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(3'b011, 0, 8'hA5, 0, 0, 8'h00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(3'b001, 0, 8'hA5, 0, 0, 8'h00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(3'b000, 1, 8'hA5, 0, 1, 8'hA5, 1, 0, 1, 0, 0));
    vecs.push_back(mk(3'b000, 1, 8'hA5, 0, 0, 8'hA5, 1, 0, 1, 0, 0));
    vecs.push_back(mk(3'b000, 0, 8'h00, 0, 0, 8'hA5, 1, 0, 1, 0, 0));
    vecs.push_back(mk(3'b000, 0, 8'h00, 0, 0, 8'hA5, 1, 0, 1, 0, 0));
    // Differing samples 0x11/0x13/0x13.
    vecs.push_back(mk(3'b111, 0, 8'h11, 0, 0, 8'hA5, 1, 0, 1, 1, 0));
    vecs.push_back(mk(3'b011, 0, 8'h13, 0, 0, 8'hA5, 1, 0, 1, 1, 0));
    vecs.push_back(mk(3'b001, 0, 8'h13, 0, 0, 8'hA5, 1, 0, 1, 1, 0));
    vecs.push_back(mk(3'b000, 1, 8'h00, 0, 1, 8'h13, 0, 0, 2, 0, MM2));
    vecs.push_back(mk(3'b000, 0, 8'h00, 0, 0, 8'h13, 0, 0, 2, 0, MM2));
    // Skipped 011 stage, ERR holds while done=1, then clear.
    vecs.push_back(mk(3'b111, 0, 8'h55, 0, 0, 8'h13, 0, 0, 2, 1, MM2));
    vecs.push_back(mk(3'b001, 0, 8'h55, 0, 0, 8'h13, 0, 1, 2, 0, MM2));
    vecs.push_back(mk(3'b000, 1, 8'h00, 0, 0, 8'h13, 0, 1, 2, 0, MM2));
    vecs.push_back(mk(3'b000, 0, 8'h00, 0, 0, 8'h13, 0, 1, 2, 0, MM2));
    vecs.push_back(mk(3'b000, 0, 8'h00, 1, 0, 8'h13, 0, 0, 2, 0, MM2));
    vecs.push_back(mk(3'b111, 0, 8'h3C, 0, 0, 8'h13, 0, 0, 2, 1, MM2));
    vecs.push_back(mk(3'b011, 0, 8'h3C, 0, 0, 8'h13, 0, 0, 2, 1, MM2));
    vecs.push_back(mk(3'b001, 0, 8'h3C, 0, 0, 8'h13, 0, 0, 2, 1, MM2));
    vecs.push_back(mk(3'b000, 1, 8'h3C, 0, 1, 8'h3C, 1, 0, 3, 0, 0));
    vecs.push_back(mk(3'b000, 0, 8'h00, 0, 0, 8'h3C, 1, 0, 3, 0, 0));
    // Abort in S2, then err_clr colliding with a fresh error from S1.
    vecs.push_back(mk(3'b111, 0, 8'h00, 0, 0, 8'h3C, 1, 0, 3, 1, 0));
    vecs.push_back(mk(3'b011, 0, 8'h00, 0, 0, 8'h3C, 1, 0, 3, 1, 0));
    vecs.push_back(mk(3'b000, 0, 8'h00, 0, 0, 8'h3C, 1, 1, 3, 0, 0));
    vecs.push_back(mk(3'b000, 0, 8'h00, 0, 0, 8'h3C, 1, 1, 3, 0, 0));
    vecs.push_back(mk(3'b000, 0, 8'h00, 1, 0, 8'h3C, 1, 0, 3, 0, 0));
    vecs.push_back(mk(3'b111, 0, 8'h00, 0, 0, 8'h3C, 1, 0, 3, 1, 0));
    vecs.push_back(mk(3'b111, 0, 8'h00, 1, 0, 8'h3C, 1, 1, 3, 0, 0));
    vecs.push_back(mk(3'b000, 0, 8'h00, 0, 0, 8'h3C, 1, 1, 3, 0, 0));
    vecs.push_back(mk(3'b000, 0, 8'h00, 1, 0, 8'h3C, 1, 0, 3, 0, 0));
    // Abort in S3 (P=000, done=0), then done=1 while IDLE.
    vecs.push_back(mk(3'b111, 0, 8'h77, 0, 0, 8'h3C, 1, 0, 3, 1, 0));
    vecs.push_back(mk(3'b011, 0, 8'h77, 0, 0, 8'h3C, 1, 0, 3, 1, 0));
    vecs.push_back(mk(3'b001, 0, 8'h77, 0, 0, 8'h3C, 1, 0, 3, 1, 0));
    vecs.push_back(mk(3'b000, 0, 8'h77, 0, 0, 8'h3C, 1, 1, 3, 0, 0));
    vecs.push_back(mk(3'b000, 0, 8'h00, 1, 0, 8'h3C, 1, 0, 3, 0, 0));
    vecs.push_back(mk(3'b000, 1, 8'h00, 0, 0, 8'h3C, 1, 1, 3, 0, 0));
    vecs.push_back(mk(3'b000, 0, 8'h00, 0, 0, 8'h3C, 1, 1, 3, 0, 0));

    rst_n = 1'b0; {ena_1, ena_2, ena_3} = 3'b000; done = 0; data_in = '0; err_clr = 0;
    validSeen = 0;
    #12;
    zero = mk(3'b000, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    checkAll(-1, zero);
    @(negedge clkB);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].p, vecs[i].dn, vecs[i].d, vecs[i].clr);
      checkAll(i, vecs[i]);
    end

    // Fresh reset, then 2^CW+1 back-to-back sequences to wrap seq_cnt.
    @(negedge clkB);
    rst_n = 1'b0;
    @(negedge clkB);
    rst_n = 1'b1;
    validSeen = 0;
    for (int k = 0; k < 17; k++) begin
      dk = 8'(k * 7 + 1);
      applyStimulus(3'b111, 0, dk, 0);
      checkOutput("wrap_valid_low", k, 32'(valid), 32'd0);
      applyStimulus(3'b011, 0, dk, 0);
      applyStimulus(3'b001, 0, dk, 0);
      applyStimulus(3'b000, 1, 8'h00, 0);
      checkOutput("wrap_valid", k, 32'(valid), 32'd1);
      checkOutput("wrap_dout",  k, 32'(data_out), 32'(dk));
      checkOutput("wrap_ack",   k, 32'(ack_tgl), 32'((k + 1) % 2));
      checkOutput("wrap_cnt",   k, 32'(seq_cnt), 32'((k + 1) % 16));
      checkOutput("wrap_err",   k, 32'(err), 32'd0);
    end
    checkOutput("wrap_pulses", 0, 32'(validSeen), 32'd17);
    checkOutput("wrap_final_cnt", 0, 32'(seq_cnt), 32'd1);

    // Asynchronous reset while in S3, then an illegal 011 start.
    applyStimulus(3'b111, 0, 8'hF0, 0);
    applyStimulus(3'b011, 0, 8'hF0, 0);
    applyStimulus(3'b001, 0, 8'hF0, 0);
    checkOutput("pre_rst_busy", 0, 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll(100, zero);
    @(negedge clkB);
    rst_n = 1'b1;
    applyStimulus(3'b011, 0, 8'h00, 0);
    checkAll(101, mk(3'b000, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
